// File: rtl/mod_hex_frame_latch_pkg.sv
// Shared VGA timing constants and staging-register state encoding for the hex overlay path.
package mod_hex_frame_latch_pkg;
  localparam int PIX_W    = 10;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int BYTES    = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HELD  = 2'd1
  } latch_state_e;
endpackage

// File: rtl/mod_hex_frame_latch_vblank.sv
// One-shot vblank-start pulse from the encoder's x/y; stalled positions yield a single pulse.
module mod_vblank_pulse
  import mod_hex_frame_latch_pkg::*;
#(
  parameter int V_ACTIVE = 480
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic [PIX_W-1:0] pix_x,
  input  logic [PIX_W-1:0] pix_y,
  output logic             vb_start
);
  logic hit, hit_q;

  assign hit = (pix_y == PIX_W'(V_ACTIVE)) && (pix_x == '0);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) hit_q <= 1'b0;
    else         hit_q <= hit;
  end

  assign vb_start = hit & ~hit_q;
endmodule

// File: rtl/mod_hex_frame_latch.sv
// Tear-free staging register: accepts a 64-bit value any time, shows it only from vblank start.
module mod_hex_frame_latch
  import mod_hex_frame_latch_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   in_clk_25_175_mhz,
  input  logic                   in_reset_n,
  input  logic [PIX_W-1:0]       in_pix_x,
  input  logic [PIX_W-1:0]       in_pix_y,
  input  logic                   in_valid,
  output logic                   out_ready,
  input  logic [63:0]            in_data,
  output logic [7:0]             out_data0,
  output logic [7:0]             out_data1,
  output logic [7:0]             out_data2,
  output logic [7:0]             out_data3,
  output logic [7:0]             out_data4,
  output logic [7:0]             out_data5,
  output logic [7:0]             out_data6,
  output logic [7:0]             out_data7,
  output logic                   out_commit,
  output logic [FRAME_CNT_W-1:0] out_frame_count
);
  // Geometry must fit the 10-bit pixel coordinates.
  if (H_ACTIVE >= (1 << PIX_W) || V_ACTIVE >= (1 << PIX_W)) begin : g_bad_geom
    $error("mod_hex_frame_latch: active area exceeds pixel coordinate width");
  end

  latch_state_e                state_q;
  logic [63:0]                 buf_q;
  logic [BYTES-1:0][7:0]       dat_q;
  logic                        commit_q;
  logic [FRAME_CNT_W-1:0]      frame_cnt_q;
  logic                        vb_start;

  mod_vblank_pulse #(.V_ACTIVE(V_ACTIVE)) u_vblank (
    .gclk     (in_clk_25_175_mhz),
    .grst_n   (in_reset_n),
    .pix_x    (in_pix_x),
    .pix_y    (in_pix_y),
    .vb_start (vb_start)
  );

  always_ff @(posedge in_clk_25_175_mhz or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q     <= EMPTY;
      buf_q       <= '0;
      dat_q       <= '0;
      commit_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      commit_q <= 1'b0;
      if (vb_start) frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
      case (state_q)
        // A vblank coinciding with the load is ignored: the value waits a full frame.
        EMPTY: if (in_valid) begin
          buf_q   <= in_data;
          state_q <= HELD;
        end
        HELD: if (vb_start) begin
          dat_q    <= buf_q;
          commit_q <= 1'b1;
          state_q  <= EMPTY;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign out_ready       = (state_q == EMPTY);
  assign out_commit      = commit_q;
  assign out_frame_count = frame_cnt_q;
  assign out_data0       = dat_q[7];
  assign out_data1       = dat_q[6];
  assign out_data2       = dat_q[5];
  assign out_data3       = dat_q[4];
  assign out_data4       = dat_q[3];
  assign out_data5       = dat_q[2];
  assign out_data6       = dat_q[1];
  assign out_data7       = dat_q[0];
endmodule

// File: tb/tb_mod_hex_frame_latch.sv
// Scoreboard bench: driver predicts commits into a queue, monitor pops on out_commit.
module tb_mod_hex_frame_latch;
  logic        clk = 1'b0;
  logic        in_reset_n = 1'b0;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_ready, out_commit, n_ready, n_commit;
  logic [7:0]  d0, d1, d2, d3, d4, d5, d6, d7;
  logic [7:0]  n0, n1, n2, n3, n4, n5, n6, n7;
  logic [15:0] out_frame_count;
  logic [3:0]  n_frame_count;

  int checks = 0, failures = 0;

  always #20 clk = ~clk;

  mod_hex_frame_latch #(.H_ACTIVE(640), .V_ACTIVE(480), .FRAME_CNT_W(16)) dut (
    .in_clk_25_175_mhz(clk), .in_reset_n(in_reset_n), .in_pix_x(pix_x), .in_pix_y(pix_y),
    .in_valid(in_valid), .out_ready(out_ready), .in_data(in_data),
    .out_data0(d0), .out_data1(d1), .out_data2(d2), .out_data3(d3),
    .out_data4(d4), .out_data5(d5), .out_data6(d6), .out_data7(d7),
    .out_commit(out_commit), .out_frame_count(out_frame_count)
  );

  // Narrow counter instance so the wrap is reachable in a short run.
  mod_hex_frame_latch #(.H_ACTIVE(640), .V_ACTIVE(480), .FRAME_CNT_W(4)) dut_w (
    .in_clk_25_175_mhz(clk), .in_reset_n(in_reset_n), .in_pix_x(pix_x), .in_pix_y(pix_y),
    .in_valid(in_valid), .out_ready(n_ready), .in_data(in_data),
    .out_data0(n0), .out_data1(n1), .out_data2(n2), .out_data3(n3),
    .out_data4(n4), .out_data5(n5), .out_data6(n6), .out_data7(n7),
    .out_commit(n_commit), .out_frame_count(n_frame_count)
  );

  wire [63:0] shown_now   = {d0, d1, d2, d3, d4, d5, d6, d7};
  wire [63:0] shown_now_w = {n0, n1, n2, n3, n4, n5, n6, n7};

  // Reference model: a one-slot mailbox emptied by each frame boundary.
  logic [63:0] offers[$];
  logic [63:0] exp_q[$];
  bit          m_full = 0;
  logic [63:0] m_buf = '0;
  bit          m_prev_at_vb = 0;
  int          m_frames = 0;
  bit          acc_last = 0;
  int          gate = 100;
  logic [63:0] shown = '0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic tick(input logic [9:0] x, input logic [9:0] y);
    bit at_vb, frame_edge;
    @(negedge clk);
    chk("ready", 64'(out_ready), 64'(!m_full));
    chk("frame_count", 64'(out_frame_count), 64'(m_frames % 65536));
    chk("frame_count_w", 64'(n_frame_count), 64'(m_frames % 16));
    if (!(in_valid && !acc_last)) begin
      if (offers.size() > 0 && $urandom_range(0, 99) < gate) begin
        in_valid = 1'b1;
        in_data  = offers.pop_front();
      end else begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
      end
    end
    pix_x = x;
    pix_y = y;
    at_vb        = (y == 10'd480) && (x == 10'd0);
    frame_edge   = at_vb && !m_prev_at_vb;
    m_prev_at_vb = at_vb;
    acc_last     = 0;
    if (frame_edge) m_frames++;
    if (m_full) begin
      if (frame_edge) begin
        exp_q.push_back(m_buf);
        m_full = 0;
      end
    end else if (in_valid) begin
      m_buf    = in_data;
      m_full   = 1;
      acc_last = 1;
    end
  endtask

  task automatic frame(input int stall);
    for (int i = 0; i < 3; i++) tick(10'($urandom_range(0, 799)), 10'($urandom_range(0, 479)));
    for (int i = 0; i < stall; i++) tick(10'd0, 10'd480);
    tick(10'd1, 10'd480);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    in_reset_n = 1'b0;
    in_valid   = 1'b1;
    in_data    = {$urandom, $urandom};
    pix_x      = 10'd3;
    pix_y      = 10'd3;
    #1;
    chk("rst_ready", 64'(out_ready), 64'd1);
    chk("rst_data", shown_now, 64'd0);
    chk("rst_count", 64'(out_frame_count), 64'd0);
    chk("rst_commit", 64'(out_commit), 64'd0);
    repeat (n) @(negedge clk);
    chk("rst_hold_data", shown_now, 64'd0);
    in_valid   = 1'b0;
    in_reset_n = 1'b1;
    m_full = 0; m_prev_at_vb = 0; m_frames = 0; acc_last = 0;
    exp_q.delete();
  endtask

  // Monitor: commits must match the predicted order; outputs hold otherwise.
  always @(negedge clk) begin
    if (!in_reset_n) begin
      shown = '0;
    end else if (out_commit) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_commit", shown_now, shown);
        failures++;
        $display("FAIL commit_without_expected actual=1 expected=0");
      end else begin
        shown = exp_q.pop_front();
        chk("commit_data", shown_now, shown);
      end
      chk("commit_data_w", shown_now_w, shown);
    end else begin
      chk("hold_data", shown_now, shown);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    do_reset(5);

    // Basic commit
    offers.push_back(64'h0123456789ABCDEF);
    tick(10'd5, 10'd100);
    for (int i = 0; i < 4; i++) tick(10'(6 + i), 10'd100);
    tick(10'd0, 10'd480);
    tick(10'd1, 10'd480);
    chk("basic_commit", 64'(out_commit), 64'd1);
    chk("basic_d0", 64'(d0), 64'h01);
    chk("basic_d7", 64'(d7), 64'hEF);
    tick(10'd2, 10'd480);
    chk("basic_pulse_width", 64'(out_commit), 64'd0);

    // Transfer coincident with vblank start waits a frame
    tick(10'd5, 10'd200);
    offers.push_back({8{8'hAA}});
    tick(10'd0, 10'd480);
    tick(10'd1, 10'd480);
    chk("coinc_hold", shown_now, 64'h0123456789ABCDEF);
    chk("coinc_no_commit", 64'(out_commit), 64'd0);
    frame(3);
    chk("coinc_late", shown_now, {8{8'hAA}});

    // Backpressure
    offers.push_back({8{8'h11}});
    offers.push_back({8{8'h55}});
    for (int i = 0; i < 4; i++) tick(10'(5 + i), 10'd100);
    chk("bp_valid_held", 64'(in_valid), 64'd1);
    frame(2);
    chk("bp_first", shown_now, {8{8'h11}});
    frame(1);
    chk("bp_second", shown_now, {8{8'h55}});

    // Stalled position and frame counting
    f0 = m_frames;
    frame(10);
    chk("stall_one", 64'(out_frame_count), 64'(f0 + 1));
    for (int i = 0; i < 3; i++) frame(1 + i);
    chk("three_frames", 64'(out_frame_count), 64'(f0 + 4));
    f0 = m_frames;
    for (int i = 0; i < 20; i++) frame(1);
    chk("narrow_wrap", 64'(n_frame_count), 64'((f0 + 20) % 16));

    // Reset with a value pending discards it
    offers.push_back({8{8'h77}});
    tick(10'd5, 10'd100);
    tick(10'd6, 10'd100);
    chk("pending_not_ready", 64'(out_ready), 64'd0);
    do_reset(3);
    frame(2);
    chk("after_reset_data", shown_now, 64'd0);

    // Randomized traffic
    gate = 40;
    for (int i = 0; i < 40; i++) begin
      if (offers.size() == 0) offers.push_back({$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) tick(10'd0, 10'd480);
      frame($urandom_range(1, 10));
    end
    gate = 0;
    frame(1);
    frame(1);
    tick(10'd9, 10'd9);
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
